// File: rtl/wave_logic_unit_pkg.sv
// Shared constants for the wave generator: semitone period ROM and height-path scaling.
package wave_pkg;

    localparam int          NUM_FREQ      = 25;
    localparam logic [4:0]  NO_WAVE_ID    = 5'd31;
    localparam logic [9:0]  WAVE_BASELINE = 10'd384;
    localparam int          WAVE_AMP      = 128;
    localparam int          C_FREQ_SHIFT  = 18;

    // round(1024 * 2^(-n/12)), n = 0..24
    localparam logic [10:0] PERIOD_ROM [NUM_FREQ] = '{
        11'd1024, 11'd967, 11'd912, 11'd861, 11'd813, 11'd767, 11'd724, 11'd683,
        11'd645,  11'd609, 11'd575, 11'd542, 11'd512, 11'd483, 11'd456, 11'd431,
        11'd406,  11'd384, 11'd362, 11'd342, 11'd323, 11'd304, 11'd287, 11'd271,
        11'd256
    };

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        COMMIT
    } wave_state_t;

    function automatic logic [10:0] period_of(input logic [4:0] id);
        return (id < 5'(NUM_FREQ)) ? PERIOD_ROM[id] : 11'd1024;
    endfunction

endpackage

// File: rtl/wave_logic_unit_if.sv
// Request/response bundle between the physics blender (master) and one wave channel (slave).
interface wave_logic_unit_if;

    logic [4:0]  freq_id;
    logic        new_f;
    logic [9:0]  index;
    logic [9:0]  wave_height;
    logic [10:0] period;
    logic [10:0] c_freq;
    logic        wave_ready;

    modport master (
        output freq_id, new_f, index,
        input  wave_height, period, c_freq, wave_ready
    );

    modport slave (
        input  freq_id, new_f, index,
        output wave_height, period, c_freq, wave_ready
    );

endinterface

// File: rtl/wave_logic_unit_sine_rom.sv
// Quarter-wave sine table with quadrant folding; 1-cycle registered signed output.
// No backpressure: accepts a new phase every cycle.
module sine_rom
    import wave_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        i_phase,
    output logic signed [8:0] o_s
);

    localparam longint PI_Q30 = 64'sd3373259426;

    // Elaboration-time round(WAVE_AMP * sin(pi*j/512)) via Q30 Taylor series.
    function automatic int q_value(input int j);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (PI_Q30 * longint'(j)) / 512;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return int'((acc * WAVE_AMP + (64'sd1 <<< 29)) >>> 30);
    endfunction

    logic [7:0] w_qtab [257];

    for (genvar g = 0; g < 257; g++) begin : g_qtab
        localparam int QV = q_value(g);
        assign w_qtab[g] = 8'(QV);
    end

    logic [7:0]        w_j;
    logic [8:0]        w_idx;
    logic [7:0]        w_mag;
    logic signed [8:0] w_mag_s;
    logic signed [8:0] r_s;

    assign w_j     = i_phase[7:0];
    assign w_idx   = i_phase[8] ? (9'd256 - {1'b0, w_j}) : {1'b0, w_j};
    assign w_mag   = w_qtab[w_idx];
    assign w_mag_s = $signed({1'b0, w_mag});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s <= '0;
        end else begin
            r_s <= i_phase[9] ? -w_mag_s : w_mag_s;
        end
    end

    assign o_s = r_s;

endmodule

// File: rtl/wave_logic_unit.sv
// Per-channel wave generator: period/c_freq load commits 21 cycles after new_f; height 2 cycles after index.
// No backpressure: one index per cycle; a new_f while dividing restarts the load.
module wave_logic_unit
    import wave_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    wave_logic_unit_if.slave bus
);

    localparam logic [4:0]  DIV_STEPS = 5'(C_FREQ_SHIFT + 1);
    localparam logic [18:0] DIV_BASE  = 19'(1) << C_FREQ_SHIFT;

    wave_state_t       r_state;
    logic [4:0]        r_pend_id;
    logic [4:0]        r_cnt;
    logic [10:0]       r_den;
    logic [18:0]       r_num;
    logic [10:0]       r_rem;
    logic [10:0]       r_quo;
    logic [4:0]        r_cur_id;
    logic [10:0]       r_period;
    logic [10:0]       r_cfreq;
    logic              r_ready;
    logic [9:0]        r_phase;
    logic              r_nowave_p1;
    logic              r_nowave_p2;

    logic [10:0]       w_pend_period;
    logic [11:0]       w_trial;
    logic              w_fits;
    logic [20:0]       w_prod;
    logic [9:0]        w_phase;
    logic signed [8:0] w_s;

    assign w_pend_period = period_of(r_pend_id);
    assign w_trial       = {r_rem, r_num[18]};
    assign w_fits        = w_trial >= {1'b0, r_den};

    // Quotient never exceeds 11 bits, so the upper quotient bits are dropped as they shift out.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pend_id <= NO_WAVE_ID;
            r_cnt     <= '0;
            r_den     <= 11'd1024;
            r_num     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cur_id  <= NO_WAVE_ID;
            r_period  <= 11'd1024;
            r_cfreq   <= 11'd256;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                end
                DIVIDE: begin
                    if (r_cnt == 5'd0) begin
                        // First DIVIDE cycle fetches the period for the latched id.
                        r_den <= w_pend_period;
                        r_num <= DIV_BASE + 19'(w_pend_period >> 1);
                        r_rem <= '0;
                        r_quo <= '0;
                    end else begin
                        r_rem <= w_fits ? 11'(w_trial - {1'b0, r_den}) : w_trial[10:0];
                        r_num <= {r_num[17:0], 1'b0};
                        r_quo <= {r_quo[9:0], w_fits};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == DIV_STEPS) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_cur_id <= r_pend_id;
                    r_period <= r_den;
                    r_cfreq  <= r_quo;
                    r_ready  <= 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // A request always wins over the divider, but a commit in this cycle still lands.
            if (bus.new_f) begin
                r_pend_id <= bus.freq_id;
                r_cnt     <= '0;
                r_state   <= DIVIDE;
            end
        end
    end

    assign w_prod  = 21'(bus.index) * 21'(r_cfreq);
    assign w_phase = 10'(w_prod >> 8);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase     <= '0;
            r_nowave_p1 <= 1'b1;
            r_nowave_p2 <= 1'b1;
        end else begin
            r_phase     <= w_phase;
            r_nowave_p1 <= (r_cur_id >= 5'(NUM_FREQ));
            r_nowave_p2 <= r_nowave_p1;
        end
    end

    sine_rom u_sine_rom (
        .clock   (clock),
        .reset   (reset),
        .i_phase (r_phase),
        .o_s     (w_s)
    );

    assign bus.wave_height = r_nowave_p2 ? WAVE_BASELINE : (WAVE_BASELINE - {w_s[8], w_s});
    assign bus.period      = r_period;
    assign bus.c_freq      = r_cfreq;
    assign bus.wave_ready  = r_ready;

endmodule

// File: tb/tb_wave_logic_unit.sv
// Self-checking bench for wave_logic_unit against a real-arithmetic reference model.
module tb_wave_logic_unit;

    localparam real PI = 3.14159265358979;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    int   m_period = 1024;
    int   m_cfreq  = 256;
    bit   m_nowave = 1'b1;

    wave_logic_unit_if bus();

    wave_logic_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic int model_period(input int id);
        if (id > 24) return 1024;
        return int'($floor(1024.0 * $pow(2.0, -id / 12.0) + 0.5));
    endfunction

    function automatic int model_cfreq(input int p);
        return int'($floor(262144.0 / p + 0.5));
    endfunction

    function automatic int model_height(input int idx, input int cf, input bit nowave);
        int  ph;
        real v;
        int  s;
        if (nowave) return 384;
        ph = ((idx * cf) >> 8) % 1024;
        v  = 128.0 * $sin(2.0 * PI * ph / 1024.0);
        s  = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
        return 384 - s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_heights(input int n, input string name);
        int exp_q[$];
        int idx;
        int e;
        for (int i = 0; i <= n; i++) begin
            idx = (i < n) ? int'($urandom_range(m_period - 1, 0)) : 0;
            bus.index = 10'(idx);
            exp_q.push_back(model_height(idx, m_cfreq, m_nowave));
            tick();
            if (i >= 1) begin
                e = exp_q.pop_front();
                total++;
                if (bus.wave_height !== 10'(e)) begin
                    bad++;
                    $display("FAIL %s height[%0d]: got %0d want %0d", name, i - 1, bus.wave_height, e);
                end
                total++;
                if (bus.wave_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s stray_ready: got %0b want 0", name, bus.wave_ready);
                end
            end
        end
    endtask

    task automatic check_fixed(input int idx, input int exp_h, input string name);
        bus.index = 10'(idx);
        tick();
        tick();
        total++;
        if (bus.wave_height !== 10'(exp_h)) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, bus.wave_height, exp_h);
        end
    endtask

    task automatic check_commit(input int exp_p, input int exp_c, input string name);
        total++;
        if (bus.wave_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_at_21: got %0b want 1", name, bus.wave_ready);
        end
        total++;
        if (bus.period !== 11'(exp_p)) begin
            bad++;
            $display("FAIL %s period: got %0d want %0d", name, bus.period, exp_p);
        end
        total++;
        if (bus.c_freq !== 11'(exp_c)) begin
            bad++;
            $display("FAIL %s c_freq: got %0d want %0d", name, bus.c_freq, exp_c);
        end
    endtask

    task automatic load_and_check(input int id, input string name);
        int exp_p;
        int exp_c;
        int early;
        int stale;
        exp_p = model_period(id);
        exp_c = model_cfreq(exp_p);
        early = 0;
        stale = 0;
        bus.freq_id = 5'(id);
        bus.new_f   = 1'b1;
        tick();
        bus.new_f   = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (bus.wave_ready !== 1'b0) early++;
            if (bus.period !== 11'(m_period) || bus.c_freq !== 11'(m_cfreq)) stale++;
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL %s early_ready: got %0d pulses want 0", name, early);
        end
        total++;
        if (stale !== 0) begin
            bad++;
            $display("FAIL %s outputs_held: got %0d changed cycles want 0", name, stale);
        end
        tick();
        check_commit(exp_p, exp_c, name);
        m_period = exp_p;
        m_cfreq  = exp_c;
        m_nowave = (id > 24);
        tick();
        total++;
        if (bus.wave_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse_width: got %0b want 0", name, bus.wave_ready);
        end
    endtask

    task automatic test_reset();
        bus.freq_id = 5'd12;
        bus.new_f   = 1'b1;
        bus.index   = '0;
        reset       = 1'b1;
        repeat (3) tick();
        reset     = 1'b0;
        bus.new_f = 1'b0;
        total++;
        if (bus.period !== 11'd1024) begin
            bad++;
            $display("FAIL reset period: got %0d want 1024", bus.period);
        end
        total++;
        if (bus.c_freq !== 11'd256) begin
            bad++;
            $display("FAIL reset c_freq: got %0d want 256", bus.c_freq);
        end
        total++;
        if (bus.wave_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset ready: got %0b want 0", bus.wave_ready);
        end
        check_heights(26, "reset_idle");
    endtask

    task automatic test_load_id12();
        load_and_check(12, "load_id12");
        check_fixed(0,   384, "id12_idx0");
        check_fixed(128, 256, "id12_idx128");
        check_fixed(256, 384, "id12_idx256");
        check_fixed(384, 512, "id12_idx384");
        check_heights(20, "id12_random");
    endtask

    task automatic test_sweep();
        load_and_check(0, "sweep_id0");
        load_and_check(1, "sweep_id1");
        check_heights(10, "id1_random");
        load_and_check(24, "sweep_id24");
        check_heights(10, "id24_random");
    endtask

    task automatic test_nowave();
        load_and_check(5, "nowave_id5");
        check_heights(10, "id5_random");
        load_and_check(31, "nowave_id31");
        check_heights(20, "id31_flat");
    endtask

    task automatic test_abort();
        int early;
        int leaked;
        early  = 0;
        leaked = 0;
        bus.freq_id = 5'd12;
        bus.new_f   = 1'b1;
        tick();
        bus.new_f   = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            tick();
            if (bus.wave_ready !== 1'b0) early++;
        end
        bus.freq_id = 5'd24;
        bus.new_f   = 1'b1;
        tick();
        bus.new_f   = 1'b0;
        for (int e = 11; e <= 30; e++) begin
            tick();
            if (bus.wave_ready !== 1'b0) early++;
            if (bus.period === 11'd512 || bus.c_freq === 11'd512) leaked++;
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL abort early_ready: got %0d pulses want 0", early);
        end
        total++;
        if (leaked !== 0) begin
            bad++;
            $display("FAIL abort id12_leak: got %0d cycles want 0", leaked);
        end
        tick();
        check_commit(256, 1024, "abort_commit");
        m_period = 256;
        m_cfreq  = 1024;
        m_nowave = 1'b0;
        tick();
        total++;
        if (bus.wave_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort pulse_width: got %0b want 0", bus.wave_ready);
        end
    endtask

    task automatic test_back_to_back();
        int pa;
        int pb;
        int early;
        pa    = model_period(7);
        pb    = model_period(16);
        early = 0;
        bus.freq_id = 5'd7;
        bus.new_f   = 1'b1;
        tick();
        bus.new_f   = 1'b0;
        for (int e = 1; e <= 20; e++) tick();
        bus.freq_id = 5'd16;
        bus.new_f   = 1'b1;
        tick();
        bus.new_f   = 1'b0;
        check_commit(pa, model_cfreq(pa), "b2b_first");
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (bus.wave_ready !== 1'b0) early++;
        end
        total++;
        if (early !== 0) begin
            bad++;
            $display("FAIL b2b early_ready: got %0d pulses want 0", early);
        end
        tick();
        check_commit(pb, model_cfreq(pb), "b2b_second");
        m_period = pb;
        m_cfreq  = model_cfreq(pb);
        m_nowave = 1'b0;
        tick();
        check_heights(12, "b2b_heights");
    endtask

    task automatic test_random_loads();
        int id;
        for (int n = 0; n < 4; n++) begin
            id = int'($urandom_range(31, 0));
            load_and_check(id, $sformatf("rand_load%0d_id%0d", n, id));
            check_heights(12, $sformatf("rand_heights%0d", n));
        end
    endtask

    task automatic test_reset_mid_load();
        int pulses;
        load_and_check(3, "pre_reset_id3");
        pulses = 0;
        bus.freq_id = 5'd20;
        bus.new_f   = 1'b1;
        tick();
        bus.new_f   = 1'b0;
        for (int e = 1; e <= 7; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (bus.wave_ready !== 1'b0) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL midreset ready: got %0d pulses want 0", pulses);
        end
        total++;
        if (bus.period !== 11'd1024) begin
            bad++;
            $display("FAIL midreset period: got %0d want 1024", bus.period);
        end
        total++;
        if (bus.c_freq !== 11'd256) begin
            bad++;
            $display("FAIL midreset c_freq: got %0d want 256", bus.c_freq);
        end
        m_period = 1024;
        m_cfreq  = 256;
        m_nowave = 1'b1;
        check_heights(10, "midreset_flat");
    endtask

    initial begin
        bus.freq_id = '0;
        bus.new_f   = 1'b0;
        bus.index   = '0;
        test_reset();
        test_load_id12();
        test_sweep();
        test_nowave();
        test_abort();
        test_back_to_back();
        test_random_loads();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
